branch_resolver: RTL and testbench
==================================

BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the datapath width; it is kept for codebase consistency and is unused internally.
REQ-002 Parameter ADDR_LENGTH, default 22, SHALL set the instruction word-address width.
REQ-003 Parameter DEPTH, default 4, power of 2, SHALL set the in-flight branch queue depth.
REQ-004 i_Clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 i_Reset_n  in  1  reset, asynchronous, active-low.
REQ-006 i_pred_valid  in  1  fetch presents a predicted branch.
REQ-007 i_pred_taken  in  1  predicted direction.
REQ-008 i_pred_addr  in  ADDR_LENGTH  branch word address.
REQ-009 i_pred_target  in  ADDR_LENGTH  predicted target.
REQ-010 o_pred_ready  out  1  queue can accept a push.
REQ-011 i_res_valid  in  1  execute resolves the oldest in-flight branch.
REQ-012 i_res_taken  in  1  actual direction.
REQ-013 i_res_target  in  ADDR_LENGTH  actual target.
REQ-014 o_res_ready  out  1  resolution accepted this cycle.
REQ-015 o_flush  out  1  one-cycle mispredict pulse.
REQ-016 o_redirect_addr  out  ADDR_LENGTH  correct fetch address; valid while o_flush=1.
REQ-017 o_upd_valid / o_upd_addr (ADDR_LENGTH) / o_upd_outcome (1)  out  training record sent to the predictor.
REQ-018 i_upd_ready  in  1  predictor accepts the training record.

Function
REQ-019 The block SHALL implement three states.
- TRACK: the reset state.
- FLUSH: entered for exactly 1 cycle on a mispredict, then TRACK.
- HOLD: entered while o_upd_valid=1 and i_upd_ready=0; exited to TRACK on the cycle i_upd_ready=1.
REQ-020 Push: on i_pred_valid & o_pred_ready, the block SHALL enqueue {addr, taken, target}. o_pred_ready = !full & state!=FLUSH.
REQ-021 Full queue: a push is refused even if a pop occurs in the same cycle.
REQ-022 Pop: on i_res_valid & o_res_ready, the block SHALL dequeue the oldest entry. o_res_ready = !empty & state==TRACK & !(o_upd_valid & !i_upd_ready).
REQ-023 Empty queue: i_res_valid while empty SHALL be ignored, with no output change.
REQ-024 Mispredict SHALL be declared when res_taken != pred_taken, or when both are taken and res_target != pred_target.
REQ-025 Redirect address on mispredict: taken -> i_res_target; not taken -> entry addr+1, modulo 2^ADDR_LENGTH (wrap-around).
REQ-026 Flush timing: o_flush and o_redirect_addr SHALL be registered and asserted the cycle after the pop; during that FLUSH cycle the entire queue SHALL be cleared, and a same-cycle push SHALL be dropped.
REQ-027 Every accepted pop SHALL load o_upd_valid=1, o_upd_addr=entry addr and o_upd_outcome=i_res_taken the following cycle.
REQ-028 o_upd_* SHALL be held stable until i_upd_ready=1, then o_upd_valid SHALL clear, unless a new pop reloads it in the same cycle.
REQ-029 Queue pointers SHALL be log2(DEPTH) bits plus a wrap bit; full when indices are equal and wrap bits differ.

Reset
REQ-030 While i_Reset_n=0, the block SHALL asynchronously force: state=TRACK; queue empty; o_flush=0; o_redirect_addr=0; o_upd_valid=0; o_upd_addr=0; o_upd_outcome=0; statistics counters=0.
REQ-031 Reset SHALL discard any in-flight entries or pending update mid-operation; o_pred_ready=1 and o_res_ready=0 on the first cycle after deassertion.

Configuration
REQ-032 Macro BRANCH_RESOLVER_STATS_EN defined: the block SHALL add outputs o_branch_count[15:0] (+1 per pop) and o_mispredict_count[15:0] (+1 per mispredict), both saturating at 16'hFFFF.
REQ-033 Macro BRANCH_RESOLVER_STATS_EN undefined: those ports and counters SHALL be absent, with all other behaviour identical.

Verification
REQ-034 Correct prediction: push {addr=0x10, taken=0}; resolve taken=0 -> o_flush stays 0; next cycle o_upd_valid=1, o_upd_addr=0x10, o_upd_outcome=0.
REQ-035 Not-taken mispredict with wrap: push {addr=0x3FFFFF, taken=1, target=0x20}; resolve taken=0 -> one-cycle o_flush=1, o_redirect_addr=0x000000, queue empty afterwards.
REQ-036 Target mismatch: push 3 entries, oldest {taken=1, target=0x40}; resolve taken=1, target=0x44 -> o_flush=1, o_redirect_addr=0x44, the 2 younger entries discarded, push during FLUSH dropped.
REQ-037 Backpressure: push 4 entries -> o_pred_ready=0; hold i_upd_ready=0 after one resolve -> o_res_ready=0, o_upd_* stable; raise i_upd_ready -> resolves resume.
REQ-038 Reset mid-operation: assert i_Reset_n=0 with 2 entries queued and an update pending -> all outputs 0 immediately; after release o_pred_ready=1, o_res_ready=0.
REQ-039 With BRANCH_RESOLVER_STATS_EN: 5 resolves including 2 mispredicts -> o_branch_count=5, o_mispredict_count=2.

Source files
------------

// File: rtl/branch_resolver_if.sv
// Branch resolver handshake bundle: prediction push channel, resolution pop
// channel, flush/redirect output and predictor training channel.
// The "slave" modport is the resolver itself. The "master" modport is the
// surrounding fetch/execute/predictor logic.
interface branch_resolver_if #(
  parameter int ADDR_LENGTH = 22
);
  // Prediction push from fetch
  logic                   i_pred_valid;
  logic                   i_pred_taken;
  logic [ADDR_LENGTH-1:0] i_pred_addr;
  logic [ADDR_LENGTH-1:0] i_pred_target;
  logic                   o_pred_ready;
  // Resolution from execute (always refers to the oldest in-flight branch)
  logic                   i_res_valid;
  logic                   i_res_taken;
  logic [ADDR_LENGTH-1:0] i_res_target;
  logic                   o_res_ready;
  // Mispredict recovery
  logic                   o_flush;
  logic [ADDR_LENGTH-1:0] o_redirect_addr;
  // Training record to the predictor
  logic                   o_upd_valid;
  logic [ADDR_LENGTH-1:0] o_upd_addr;
  logic                   o_upd_outcome;
  logic                   i_upd_ready;

  modport slave (
    input  i_pred_valid, i_pred_taken, i_pred_addr, i_pred_target,
    input  i_res_valid, i_res_taken, i_res_target, i_upd_ready,
    output o_pred_ready, o_res_ready, o_flush, o_redirect_addr,
    output o_upd_valid, o_upd_addr, o_upd_outcome
  );

  modport master (
    output i_pred_valid, i_pred_taken, i_pred_addr, i_pred_target,
    output i_res_valid, i_res_taken, i_res_target, i_upd_ready,
    input  o_pred_ready, o_res_ready, o_flush, o_redirect_addr,
    input  o_upd_valid, o_upd_addr, o_upd_outcome
  );
endinterface

// File: rtl/branch_resolver.sv
// Branch resolver: keeps a FIFO of in-flight predicted branches, compares each
// against its resolution from execute, raises a one-cycle flush with the
// correct fetch address on a mispredict, and emits a training record to the
// predictor for every resolved branch.
// Optional feature: define BRANCH_RESOLVER_STATS_EN to add saturating 16-bit
// resolved-branch and mispredict counters as extra outputs.
module branch_resolver #(
  parameter int DATA_WIDTH  = 32,  // datapath width, not used internally
  parameter int ADDR_LENGTH = 22,  // instruction word-address width
  parameter int DEPTH       = 4    // in-flight queue depth, power of two
) (
  input  logic                i_Clk,
  input  logic                i_Reset_n,
  branch_resolver_if.slave    bus
`ifdef BRANCH_RESOLVER_STATS_EN
  ,
  output logic [15:0]         o_branch_count,
  output logic [15:0]         o_mispredict_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (DATA_WIDTH < 1)) begin : g_bad_params
    $error("branch_resolver: DEPTH must be a power of two >= 2 and DATA_WIDTH >= 1");
  end

  typedef enum logic [1:0] {
    TRACK = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Queue storage and pointers (index plus wrap bit)
  logic [ADDR_LENGTH-1:0] r_q_addr   [DEPTH];
  logic                   r_q_taken  [DEPTH];
  logic [ADDR_LENGTH-1:0] r_q_target [DEPTH];
  logic [PTR_W:0]         r_wr_ptr;
  logic [PTR_W:0]         r_rd_ptr;

  logic [ADDR_LENGTH-1:0] r_redirect_addr;
  logic                   r_upd_valid;
  logic [ADDR_LENGTH-1:0] r_upd_addr;
  logic                   r_upd_outcome;

  logic                   w_empty;
  logic                   w_full;
  logic                   w_upd_stall;
  logic                   w_pred_ready;
  logic                   w_res_ready;
  logic                   w_push;
  logic                   w_pop;
  logic [ADDR_LENGTH-1:0] w_head_addr;
  logic                   w_head_taken;
  logic [ADDR_LENGTH-1:0] w_head_target;
  logic                   w_mispredict;
  logic                   w_mispredict_pop;
  logic [ADDR_LENGTH-1:0] w_fallthrough;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]) &&
                   (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);

  // A training record still waiting on the predictor blocks further pops so
  // it cannot be overwritten.
  assign w_upd_stall  = r_upd_valid && !bus.i_upd_ready;

  // Full refuses a push even when a pop frees a slot in the same cycle.
  assign w_pred_ready = !w_full && (r_state != FLUSH);
  assign w_res_ready  = !w_empty && (r_state == TRACK) && !w_upd_stall;

  assign w_push = bus.i_pred_valid && w_pred_ready;
  assign w_pop  = bus.i_res_valid  && w_res_ready;

  assign w_head_addr   = r_q_addr[r_rd_ptr[PTR_W-1:0]];
  assign w_head_taken  = r_q_taken[r_rd_ptr[PTR_W-1:0]];
  assign w_head_target = r_q_target[r_rd_ptr[PTR_W-1:0]];

  // Wrong direction, or right "taken" direction but wrong target.
  assign w_mispredict = (w_head_taken != bus.i_res_taken) ||
                        (w_head_taken && bus.i_res_taken &&
                         (w_head_target != bus.i_res_target));
  assign w_mispredict_pop = w_pop && w_mispredict;

  // Sequential fall-through address wraps modulo 2^ADDR_LENGTH.
  assign w_fallthrough = w_head_addr + ADDR_LENGTH'(1);

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) r_state <= TRACK;
    else            r_state <= w_state_next;
  end

  // Next-state: mispredict -> FLUSH for one cycle; stalled training -> HOLD
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      TRACK: begin
        if (w_mispredict_pop)  w_state_next = FLUSH;
        else if (w_upd_stall)  w_state_next = HOLD;
      end
      FLUSH:   w_state_next = TRACK;
      HOLD: begin
        if (bus.i_upd_ready)   w_state_next = TRACK;
      end
      default: w_state_next = TRACK;
    endcase
  end

  // Queue pointers; the FLUSH cycle empties the whole queue
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (r_state == FLUSH) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Queue payload write
  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, so resetting the array would only cost area.
  always_ff @(posedge i_Clk) begin
    if (w_push) begin
      r_q_addr[r_wr_ptr[PTR_W-1:0]]   <= bus.i_pred_addr;
      r_q_taken[r_wr_ptr[PTR_W-1:0]]  <= bus.i_pred_taken;
      r_q_target[r_wr_ptr[PTR_W-1:0]] <= bus.i_pred_target;
    end
  end

  // Redirect address captured on the mispredicting pop
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n)            r_redirect_addr <= '0;
    else if (w_mispredict_pop) r_redirect_addr <= bus.i_res_taken ? bus.i_res_target
                                                                  : w_fallthrough;
  end

  // Training record: loaded by each pop, held until the predictor accepts it
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_upd_valid   <= 1'b0;
      r_upd_addr    <= '0;
      r_upd_outcome <= 1'b0;
    end else if (w_pop) begin
      r_upd_valid   <= 1'b1;
      r_upd_addr    <= w_head_addr;
      r_upd_outcome <= bus.i_res_taken;
    end else if (bus.i_upd_ready) begin
      r_upd_valid   <= 1'b0;
    end
  end

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [15:0] r_branch_count;
  logic [15:0] r_mispredict_count;

  // Saturating statistics counters
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_pop && (r_branch_count != 16'hFFFF))
        r_branch_count <= r_branch_count + 16'd1;
      if (w_mispredict_pop && (r_mispredict_count != 16'hFFFF))
        r_mispredict_count <= r_mispredict_count + 16'd1;
    end
  end

  assign o_branch_count     = r_branch_count;
  assign o_mispredict_count = r_mispredict_count;
`endif

  assign bus.o_pred_ready    = w_pred_ready;
  assign bus.o_res_ready     = w_res_ready;
  assign bus.o_flush         = (r_state == FLUSH);
  assign bus.o_redirect_addr = r_redirect_addr;
  assign bus.o_upd_valid     = r_upd_valid;
  assign bus.o_upd_addr      = r_upd_addr;
  assign bus.o_upd_outcome   = r_upd_outcome;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver. The stimulus tasks push the hand-computed
// training records and redirect addresses into queues. A monitor process pops
// and compares whenever the DUT hands over a training record or raises flush.
module tb_branch_resolver;

  localparam int AW = 22;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          outcome;
  } upd_t;

  logic i_Clk;
  logic i_Reset_n;

  branch_resolver_if #(.ADDR_LENGTH(AW)) bus ();

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [15:0] w_branch_count;
  logic [15:0] w_mispredict_count;
`endif

  branch_resolver #(
    .DATA_WIDTH (32),
    .ADDR_LENGTH(AW),
    .DEPTH      (4)
  ) u_dut (
    .i_Clk    (i_Clk),
    .i_Reset_n(i_Reset_n),
    .bus      (bus)
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    .o_branch_count    (w_branch_count),
    .o_mispredict_count(w_mispredict_count)
`endif
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  int            n_vec = 0;
  int            n_err = 0;
  upd_t          exp_upd[$];
  logic [AW-1:0] exp_flush[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic t, input logic [AW-1:0] tg,
                      input logic exp_ready);
    bus.i_pred_valid  = 1'b1;
    bus.i_pred_addr   = a;
    bus.i_pred_taken  = t;
    bus.i_pred_target = tg;
    @(negedge i_Clk);
    check("pred_ready_on_push", bus.o_pred_ready, exp_ready);
    tick();
    bus.i_pred_valid = 1'b0;
  endtask

  // Resolve the oldest entry; waits (bounded) for o_res_ready.
  task automatic resolve(input logic t, input logic [AW-1:0] tg, input logic [AW-1:0] exp_addr,
                         input logic exp_mis, input logic [AW-1:0] exp_redir);
    int n;
    upd_t u;
    bus.i_res_valid  = 1'b1;
    bus.i_res_taken  = t;
    bus.i_res_target = tg;
    n = 0;
    @(negedge i_Clk);
    while (!bus.o_res_ready && n < 8) begin
      n++;
      @(negedge i_Clk);
    end
    check("res_ready_wait", bus.o_res_ready, 1'b1);
    if (bus.o_res_ready) begin
      u.addr    = exp_addr;
      u.outcome = t;
      exp_upd.push_back(u);
      if (exp_mis) exp_flush.push_back(exp_redir);
    end
    tick();
    bus.i_res_valid = 1'b0;
  endtask

  // Monitor: compares each accepted training record and each flush pulse.
  initial begin : monitor
    upd_t          e;
    logic [AW-1:0] r;
    forever begin
      @(negedge i_Clk);
      if (bus.o_upd_valid && bus.i_upd_ready) begin
        if (exp_upd.size() == 0) begin
          check("upd_unexpected", bus.o_upd_valid, 1'b0);
        end else begin
          e = exp_upd.pop_front();
          check("upd_addr", bus.o_upd_addr, e.addr);
          check("upd_outcome", bus.o_upd_outcome, e.outcome);
        end
      end
      if (bus.o_flush) begin
        if (exp_flush.size() == 0) begin
          check("flush_unexpected", bus.o_flush, 1'b0);
        end else begin
          r = exp_flush.pop_front();
          check("redirect_addr", bus.o_redirect_addr, r);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    i_Reset_n         = 1'b0;
    bus.i_pred_valid  = 1'b0;
    bus.i_pred_taken  = 1'b0;
    bus.i_pred_addr   = '0;
    bus.i_pred_target = '0;
    bus.i_res_valid   = 1'b0;
    bus.i_res_taken   = 1'b0;
    bus.i_res_target  = '0;
    bus.i_upd_ready   = 1'b1;

    // Reset state
    #3;
    check("rst_flush", bus.o_flush, 1'b0);
    check("rst_redirect", bus.o_redirect_addr, '0);
    check("rst_upd_valid", bus.o_upd_valid, 1'b0);
    check("rst_res_ready", bus.o_res_ready, 1'b0);
    @(posedge i_Clk);
    #3 i_Reset_n = 1'b1;
    tick();
    check("post_rst_pred_ready", bus.o_pred_ready, 1'b1);
    check("post_rst_res_ready", bus.o_res_ready, 1'b0);

    // Correct not-taken prediction: no flush, record {0x10, 0}
    push(22'h10, 1'b0, 22'h0, 1'b1);
    resolve(1'b0, 22'h0, 22'h10, 1'b0, 22'h0);
    tick();

    // Not-taken mispredict at the top of the address space wraps to 0
    push(22'h3FFFFF, 1'b1, 22'h20, 1'b1);
    resolve(1'b0, 22'h0, 22'h3FFFFF, 1'b1, 22'h000000);
    tick();
    check("t2_flush_one_cycle", bus.o_flush, 1'b0);
    check("t2_empty_res_ready", bus.o_res_ready, 1'b0);
    check("t2_pred_ready", bus.o_pred_ready, 1'b1);

    // Target mismatch with two younger entries; push during FLUSH is dropped
    push(22'h100, 1'b1, 22'h40, 1'b1);
    push(22'h104, 1'b0, 22'h0, 1'b1);
    push(22'h108, 1'b1, 22'h80, 1'b1);
    resolve(1'b1, 22'h44, 22'h100, 1'b1, 22'h44);
    bus.i_pred_valid = 1'b1;
    bus.i_pred_addr  = 22'h200;
    bus.i_pred_taken = 1'b0;
    check("t3_pred_ready_in_flush", bus.o_pred_ready, 1'b0);
    tick();
    bus.i_pred_valid = 1'b0;
    check("t3_queue_cleared", bus.o_res_ready, 1'b0);

    // Resolution against an empty queue is ignored
    bus.i_res_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge i_Clk);
      check("empty_res_ready", bus.o_res_ready, 1'b0);
      tick();
    end
    bus.i_res_valid = 1'b0;

    // Fill the queue; a push alongside a pop on a full queue is refused
    push(22'h300, 1'b0, 22'h0, 1'b1);
    push(22'h301, 1'b1, 22'h50, 1'b1);
    push(22'h302, 1'b0, 22'h0, 1'b1);
    push(22'h303, 1'b1, 22'h60, 1'b1);
    check("t4_full_pred_ready", bus.o_pred_ready, 1'b0);
    bus.i_pred_valid = 1'b1;
    bus.i_pred_addr  = 22'h3FF;
    resolve(1'b0, 22'h0, 22'h300, 1'b0, 22'h0);
    bus.i_pred_valid = 1'b0;
    bus.i_upd_ready  = 1'b0;
    push(22'h3AA, 1'b0, 22'h0, 1'b1);
    check("t4_refill_full", bus.o_pred_ready, 1'b0);

    // Predictor backpressure: pops blocked, record held stable
    for (int i = 0; i < 3; i++) begin
      @(negedge i_Clk);
      check("hold_res_ready", bus.o_res_ready, 1'b0);
      check("hold_upd_valid", bus.o_upd_valid, 1'b1);
      check("hold_upd_addr", bus.o_upd_addr, 22'h300);
      check("hold_upd_outcome", bus.o_upd_outcome, 1'b0);
      tick();
    end
    bus.i_upd_ready = 1'b1;
    resolve(1'b1, 22'h50, 22'h301, 1'b0, 22'h0);
    resolve(1'b1, 22'h77, 22'h302, 1'b1, 22'h77);
    tick();
    check("t4_flushed_empty", bus.o_res_ready, 1'b0);
`ifdef BRANCH_RESOLVER_STATS_EN
    check("stats_branch_count", w_branch_count, 16'd6);
    check("stats_mispredict_count", w_mispredict_count, 16'd3);
`endif

    // Reset mid-operation: two entries queued, a training record pending
    push(22'h500, 1'b1, 22'h10, 1'b1);
    push(22'h501, 1'b0, 22'h0, 1'b1);
    push(22'h502, 1'b0, 22'h0, 1'b1);
    bus.i_upd_ready = 1'b0;
    resolve(1'b1, 22'h10, 22'h500, 1'b0, 22'h0);
    tick();
    #2 i_Reset_n = 1'b0;
    #1;
    check("mid_rst_upd_valid", bus.o_upd_valid, 1'b0);
    check("mid_rst_upd_addr", bus.o_upd_addr, '0);
    check("mid_rst_upd_outcome", bus.o_upd_outcome, 1'b0);
    check("mid_rst_flush", bus.o_flush, 1'b0);
    check("mid_rst_redirect", bus.o_redirect_addr, '0);
    check("mid_rst_res_ready", bus.o_res_ready, 1'b0);
`ifdef BRANCH_RESOLVER_STATS_EN
    check("mid_rst_branch_count", w_branch_count, 16'd0);
`endif
    exp_upd.delete();
    #3 i_Reset_n = 1'b1;
    tick();
    check("rel_pred_ready", bus.o_pred_ready, 1'b1);
    check("rel_res_ready", bus.o_res_ready, 1'b0);
    check("rel_upd_valid", bus.o_upd_valid, 1'b0);
    bus.i_upd_ready = 1'b1;

    // Redirect selection: not-taken fall-through and taken target
    push(22'h1234, 1'b1, 22'h99, 1'b1);
    resolve(1'b0, 22'h0, 22'h1234, 1'b1, 22'h1235);
    tick();
    push(22'h2000, 1'b0, 22'h0, 1'b1);
    resolve(1'b1, 22'h2A0, 22'h2000, 1'b1, 22'h2A0);
    tick();
    tick();
`ifdef BRANCH_RESOLVER_STATS_EN
    check("stats2_branch_count", w_branch_count, 16'd2);
    check("stats2_mispredict_count", w_mispredict_count, 16'd2);
`endif

    // Every expected record and flush must have been observed
    check("upd_queue_drained", exp_upd.size(), 0);
    check("flush_queue_drained", exp_flush.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
